detector_readout: RTL and testbench
===================================

# detector_readout

Digital readout stage placed directly downstream of the final on-chip `detector`, which produces the assay's `Out` signal. It waits a programmable settle time after the upstream flow is started, then averages a fixed power-of-two number of digitized detector samples. It compares the average against a threshold and hands the result to the host logic over a valid/ready handshake. This is the first clocked element behind the fluidic netlist and turns the terminal detector reading into a single qualified measurement per run.

## Interface
- `DATA_W`, 12, width of a detector sample and of the result.
- `AVG_LOG2`, 3, log2 of the number of samples averaged (N = 2^AVG_LOG2; legal 0..8).
- `SETTLE_CYC`, 4, clock cycles to wait after `start` before accepting samples (0 = no wait).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  one-cycle request to begin a measurement; honoured only in IDLE.
- `abort`  in  1  synchronous cancel; returns to IDLE from any state and discards partial data.
- `sample_valid`  in  1  `sample_data` is a new detector conversion this cycle.
- `sample_data`  in  DATA_W  unsigned detector reading.
- `thresh`  in  DATA_W  unsigned hit threshold, sampled when the result is formed.
- `busy`  out  1  high in every state except IDLE.
- `result_valid`  out  1  result available (REPORT state).
- `result_ready`  in  1  consumer accepts the result.
- `result_data`  out  DATA_W  averaged reading.
- `result_hit`  out  1  `result_data >= thresh`.
- `overrun`  out  1  one-cycle pulse when a `sample_valid` arrives in REPORT and is dropped.

## Operation
- FSM states: IDLE, SETTLE, ACQUIRE, REPORT.
- IDLE: `start`=1 goes to SETTLE, loading the settle counter with SETTLE_CYC. If SETTLE_CYC=0, it goes straight to ACQUIRE. It clears the accumulator and the sample counter.
- SETTLE: the counter decrements once per cycle. When it reaches 1, the next state is ACQUIRE. Samples are ignored in this state and `overrun` stays 0.
- ACQUIRE: each cycle with `sample_valid`=1, `sample_data` is added to the accumulator and the sample counter increments.
  - On the cycle the Nth sample is accepted, the next state is REPORT.
  - In that same edge, `result_data` <= (acc + sample) >> AVG_LOG2, truncating, and `result_hit` <= that value >= `thresh`.
- REPORT: `result_data` and `result_hit` are held stable while `result_valid`=1. On `result_valid && result_ready`, the next state is IDLE.
  - A `start` in the same cycle as acceptance is ignored.
  - A `sample_valid` in REPORT pulses `overrun` for one cycle and is not accumulated.
- Accumulator width is DATA_W+AVG_LOG2. It never overflows, because N maximum samples equals 2^AVG_LOG2·(2^DATA_W−1).
- Sample counter width is AVG_LOG2+1.
- `abort` has priority over every other input, including the REPORT handshake. It moves the FSM to IDLE on the next edge, clears the accumulator and counter, and drops `result_valid`. `result_data` and `result_hit` keep their last values.
- `start` outside IDLE is ignored; no queuing.

## Timing
- Reset values: state IDLE, `busy`=0, `result_valid`=0, `result_data`=0, `result_hit`=0, `overrun`=0, accumulator and counters 0.
- Reset assertion clears the block immediately, even mid-ACQUIRE or mid-REPORT. The first edge after deassertion behaves as IDLE.
- Cycle-by-cycle sequence, with `start` sampled at edge t:
  - `busy`=1 from t+1.
  - ACQUIRE from t+1+SETTLE_CYC.
- Minimum latency from the last sample accepted to `result_valid`: 1 cycle (registered).
- With back-to-back samples and `result_ready` tied high, REPORT lasts exactly 1 cycle. Start to IDLE takes SETTLE_CYC + N + 2 cycles.
- A new `start` can be honoured on the first cycle back in IDLE. Throughput is one measurement per SETTLE_CYC+N+2 cycles.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Basic average: defaults, `start`, 8 samples of 100, `thresh`=100 → `result_data`=100, `result_hit`=1, `result_valid` 4+8+1 cycles after `start`.
- Truncation and gaps: samples 0..7 with idle cycles between them → result 3 (28>>3), `thresh`=4 → `result_hit`=0; samples during SETTLE ignored.
- Full scale: 8 samples of 4095 → result 4095, no wrap; `thresh`=0 → hit=1.
- Backpressure and overrun: hold `result_ready`=0 for 5 cycles with `sample_valid` high → result stable, `overrun` pulses 5 times, `start` ignored; release → IDLE next cycle.
- Abort and reset: `abort` after 3 samples → IDLE, next run's result unaffected by those samples. `rst_n` low mid-REPORT → `result_valid`=0 immediately.
- Parameter corners: AVG_LOG2=0, SETTLE_CYC=0 → single sample 77 yields result 77 two cycles after `start`.

Source files
------------

// File: rtl/detector_readout.sv
// Readout stage behind the terminal detector: waits a settle time after start,
// averages 2^AVG_LOG2 samples, compares against a threshold and offers the result.
module detector_readout #(
    parameter int DATA_W     = 12,
    parameter int AVG_LOG2   = 3,
    parameter int SETTLE_CYC = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    input  logic [DATA_W-1:0] thresh,
    output logic              busy,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [DATA_W-1:0] result_data,
    output logic              result_hit,
    output logic              overrun
);

    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int SET_W = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);

    localparam logic [CNT_W-1:0] LAST_IDX    = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYC);
    localparam logic [SET_W-1:0] SETTLE_ONE  = SET_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        ACQUIRE,
        REPORT
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [SET_W-1:0]  settle_cnt;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  sample_cnt;
    logic [ACC_W-1:0]  acc_sum;
    logic [DATA_W-1:0] avg;
    logic              last_sample;
    logic              take_sample;
    logic              settle_load;
    logic              clear_acc;
    logic              drop_sample;

    // The accumulator is sized for N full-scale samples, so this sum cannot wrap.
    assign acc_sum     = acc + ACC_W'(sample_data);
    assign avg         = acc_sum[AVG_LOG2 +: DATA_W];
    assign last_sample = (sample_cnt == LAST_IDX);
    assign drop_sample = !abort && (state == REPORT) && sample_valid;

    // NOTE: every signal driven here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_next  = state;
        settle_load = 1'b0;
        clear_acc   = 1'b0;
        take_sample = 1'b0;
        if (abort) begin
            state_next = IDLE;
            clear_acc  = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    clear_acc = 1'b1;
                    if (start) begin
                        if (SETTLE_CYC == 0) begin
                            state_next = ACQUIRE;
                        end else begin
                            state_next  = SETTLE;
                            settle_load = 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    if (settle_cnt <= SETTLE_ONE) begin
                        state_next = ACQUIRE;
                    end
                end
                ACQUIRE: begin
                    if (sample_valid) begin
                        take_sample = 1'b1;
                        if (last_sample) begin
                            state_next = REPORT;
                        end
                    end
                end
                REPORT: begin
                    if (result_ready) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // busy and result_valid are flopped from the next state so every output
    // leaves a register.
    // NOTE: sequential state uses non-blocking assignments so all flops update
    // together from the values present before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            busy         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_next;
            busy         <= (state_next != IDLE);
            result_valid <= (state_next == REPORT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt  <= '0;
            acc         <= '0;
            sample_cnt  <= '0;
            result_data <= '0;
            result_hit  <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            overrun <= drop_sample;

            if (settle_load) begin
                settle_cnt <= SETTLE_LOAD;
            end else if (state == SETTLE && settle_cnt != '0) begin
                settle_cnt <= settle_cnt - 1'b1;
            end

            // Result registers are left untouched by abort; only a new run replaces them.
            if (clear_acc) begin
                acc        <= '0;
                sample_cnt <= '0;
            end else if (take_sample) begin
                acc        <= acc_sum;
                sample_cnt <= sample_cnt + 1'b1;
                if (last_sample) begin
                    result_data <= avg;
                    result_hit  <= (avg >= thresh);
                end
            end
        end
    end

endmodule

// File: tb/tb_detector_readout.sv
// Randomized bench for detector_readout: a default-parameter instance plus an
// AVG_LOG2=0 / SETTLE_CYC=0 instance, checked against an averaging model.
module tb_detector_readout;

    localparam int DW = 12;
    localparam int AL = 3;
    localparam int SC = 4;
    localparam int N  = 1 << AL;

    typedef logic [DW-1:0] sample_t;
    typedef sample_t vec_t[N];
    typedef int gap_t[N];

    logic    clk = 1'b0;
    logic    rst_n;
    logic    start, abort, sample_valid, result_ready;
    sample_t sample_data, thresh;
    logic    busy, result_valid, result_hit, overrun;
    sample_t result_data;

    logic    c_start, c_abort, c_sample_valid, c_result_ready;
    sample_t c_sample_data, c_thresh;
    logic    c_busy, c_result_valid, c_result_hit, c_overrun;
    sample_t c_result_data;

    int      vectors     = 0;
    int      miscompares = 0;
    sample_t last_data;
    logic    last_hit;

    always #5 clk = ~clk;

    detector_readout #(.DATA_W(DW), .AVG_LOG2(AL), .SETTLE_CYC(SC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .sample_valid(sample_valid), .sample_data(sample_data), .thresh(thresh),
        .busy(busy), .result_valid(result_valid), .result_ready(result_ready),
        .result_data(result_data), .result_hit(result_hit), .overrun(overrun)
    );

    detector_readout #(.DATA_W(DW), .AVG_LOG2(0), .SETTLE_CYC(0)) dut_corner (
        .clk(clk), .rst_n(rst_n), .start(c_start), .abort(c_abort),
        .sample_valid(c_sample_valid), .sample_data(c_sample_data), .thresh(c_thresh),
        .busy(c_busy), .result_valid(c_result_valid), .result_ready(c_result_ready),
        .result_data(c_result_data), .result_hit(c_result_hit), .overrun(c_overrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a run, optionally wiggles sample_valid during the settle window,
    // feeds vals with the given idle gaps and checks the averaged result.
    task automatic run_measure(input string name, input vec_t vals, input gap_t gaps,
                               input sample_t th, input bit noise);
        int      sum = 0;
        sample_t exp_data;
        logic    exp_hit;
        foreach (vals[i]) sum += int'(vals[i]);
        exp_data = sample_t'(sum / N);
        exp_hit  = (exp_data >= th);

        thresh = th;
        start  = 1'b1;
        tick();
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s busy_after_start: got %b expected 1", name, busy);
        end
        for (int k = 0; k < SC; k++) begin
            sample_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            sample_data  = sample_t'($urandom);
            tick();
            vectors++;
            if (overrun !== 1'b0 || result_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL %s settle_quiet: got overrun=%b valid=%b expected 0 0",
                         name, overrun, result_valid);
            end
        end
        for (int i = 0; i < N; i++) begin
            for (int g = 0; g < gaps[i]; g++) begin
                sample_valid = 1'b0;
                sample_data  = sample_t'($urandom);
                tick();
            end
            sample_valid = 1'b1;
            sample_data  = vals[i];
            tick();
            vectors++;
            if (result_valid !== (i == N - 1)) begin
                miscompares++;
                $display("FAIL %s valid_timing[%0d]: got %b expected %b",
                         name, i, result_valid, (i == N - 1));
            end
        end
        sample_valid = 1'b0;
        vectors++;
        if (result_data !== exp_data || result_hit !== exp_hit) begin
            miscompares++;
            $display("FAIL %s result: got data=%0d hit=%b expected data=%0d hit=%b",
                     name, result_data, result_hit, exp_data, exp_hit);
        end
        last_data = exp_data;
        last_hit  = exp_hit;
    endtask

    task automatic accept(input string name);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        vectors++;
        if (result_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s accept: got valid=%b busy=%b expected 0 0",
                     name, result_valid, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 0; abort = 0; sample_valid = 0; result_ready = 0;
        sample_data = '0; thresh = '0;
        c_start = 0; c_abort = 0; c_sample_valid = 0; c_result_ready = 0;
        c_sample_data = '0; c_thresh = '0;
        repeat (3) tick();
        vectors++;
        if ({busy, result_valid, result_hit, overrun} !== 4'b0000 || result_data !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got busy=%b valid=%b hit=%b ovr=%b data=%0d expected all 0",
                     busy, result_valid, result_hit, overrun, result_data);
        end
        vectors++;
        if ({c_busy, c_result_valid, c_result_hit, c_overrun} !== 4'b0000 || c_result_data !== '0) begin
            miscompares++;
            $display("FAIL reset_state_corner: got busy=%b valid=%b data=%0d expected 0 0 0",
                     c_busy, c_result_valid, c_result_data);
        end
        rst_n = 1'b1;
        tick();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_basic();
        vec_t v;
        gap_t g;
        foreach (v[i]) begin v[i] = 12'd100; g[i] = 0; end
        run_measure("basic", v, g, 12'd100, 1'b0);
        accept("basic");
    endtask

    task automatic test_truncation();
        vec_t v;
        gap_t g;
        foreach (v[i]) begin v[i] = sample_t'(i); g[i] = int'($urandom_range(1, 3)); end
        run_measure("truncation", v, g, 12'd4, 1'b1);
        accept("truncation");
    endtask

    task automatic test_full_scale();
        vec_t v;
        gap_t g;
        foreach (v[i]) begin v[i] = 12'hFFF; g[i] = 0; end
        run_measure("full_scale", v, g, 12'd0, 1'b1);
        accept("full_scale");
    endtask

    task automatic test_random();
        vec_t v;
        gap_t g;
        for (int r = 0; r < 8; r++) begin
            foreach (v[i]) begin v[i] = sample_t'($urandom); g[i] = int'($urandom_range(0, 2)); end
            run_measure("random", v, g, sample_t'($urandom_range(1024, 3072)), 1'b1);
            accept("random");
        end
    endtask

    task automatic test_back_to_back();
        vec_t v;
        gap_t g;
        for (int r = 0; r < 3; r++) begin
            foreach (v[i]) begin v[i] = sample_t'($urandom); g[i] = 0; end
            run_measure("back_to_back", v, g, sample_t'($urandom), 1'b0);
            accept("back_to_back");
        end
    endtask

    task automatic test_backpressure();
        vec_t v;
        gap_t g;
        int   pulses = 0;
        foreach (v[i]) begin v[i] = sample_t'($urandom); g[i] = 0; end
        run_measure("backpressure", v, g, 12'd2048, 1'b0);
        for (int k = 0; k < 5; k++) begin
            sample_valid = 1'b1;
            sample_data  = sample_t'($urandom);
            start        = 1'b1;
            tick();
            if (overrun === 1'b1) pulses++;
            vectors++;
            if (result_valid !== 1'b1 || result_data !== last_data || result_hit !== last_hit) begin
                miscompares++;
                $display("FAIL backpressure_hold[%0d]: got valid=%b data=%0d hit=%b expected 1 %0d %b",
                         k, result_valid, result_data, result_hit, last_data, last_hit);
            end
        end
        vectors++;
        if (pulses !== 5) begin
            miscompares++;
            $display("FAIL overrun_count: got %0d expected 5", pulses);
        end
        sample_valid = 1'b0;
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        start        = 1'b0;
        vectors++;
        if (result_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL backpressure_release: got valid=%b busy=%b ovr=%b expected 0 0 0",
                     result_valid, busy, overrun);
        end
        tick();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL start_not_queued: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_abort();
        vec_t v;
        gap_t g;
        thresh = 12'd0;
        start  = 1'b1;
        tick();
        start = 1'b0;
        repeat (SC) tick();
        for (int i = 0; i < 3; i++) begin
            sample_valid = 1'b1;
            sample_data  = 12'hFFF;
            tick();
        end
        abort = 1'b1;
        tick();
        abort        = 1'b0;
        sample_valid = 1'b0;
        vectors++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || result_data !== last_data || result_hit !== last_hit) begin
            miscompares++;
            $display("FAIL abort_acquire: got busy=%b valid=%b data=%0d hit=%b expected 0 0 %0d %b",
                     busy, result_valid, result_data, result_hit, last_data, last_hit);
        end
        foreach (v[i]) begin v[i] = sample_t'($urandom_range(0, 200)); g[i] = 0; end
        run_measure("after_abort", v, g, 12'd100, 1'b0);
        abort        = 1'b1;
        result_ready = 1'b1;
        tick();
        abort        = 1'b0;
        result_ready = 1'b0;
        vectors++;
        if (result_valid !== 1'b0 || busy !== 1'b0 || result_data !== last_data) begin
            miscompares++;
            $display("FAIL abort_report: got valid=%b busy=%b data=%0d expected 0 0 %0d",
                     result_valid, busy, result_data, last_data);
        end
    endtask

    task automatic test_reset_mid_report();
        vec_t v;
        gap_t g;
        foreach (v[i]) begin v[i] = sample_t'($urandom_range(1, 4095)); g[i] = 0; end
        run_measure("pre_reset", v, g, 12'd0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (result_valid !== 1'b0 || busy !== 1'b0 || result_data !== '0 || result_hit !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_report: got valid=%b busy=%b data=%0d hit=%b expected 0 0 0 0",
                     result_valid, busy, result_data, result_hit);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_corner();
        for (int r = 0; r < 4; r++) begin
            sample_t s;
            sample_t th;
            s  = (r == 0) ? 12'd77 : sample_t'($urandom);
            th = (r == 0) ? 12'd77 : sample_t'($urandom);
            c_thresh = th;
            c_start  = 1'b1;
            tick();
            c_start = 1'b0;
            vectors++;
            if (c_busy !== 1'b1 || c_result_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL corner_start[%0d]: got busy=%b valid=%b expected 1 0",
                         r, c_busy, c_result_valid);
            end
            c_sample_valid = 1'b1;
            c_sample_data  = s;
            tick();
            c_sample_valid = 1'b0;
            vectors++;
            if (c_result_valid !== 1'b1 || c_result_data !== s || c_result_hit !== (s >= th)) begin
                miscompares++;
                $display("FAIL corner_result[%0d]: got valid=%b data=%0d hit=%b expected 1 %0d %b",
                         r, c_result_valid, c_result_data, c_result_hit, s, (s >= th));
            end
            c_result_ready = 1'b1;
            tick();
            c_result_ready = 1'b0;
            vectors++;
            if (c_result_valid !== 1'b0 || c_busy !== 1'b0) begin
                miscompares++;
                $display("FAIL corner_accept[%0d]: got valid=%b busy=%b expected 0 0",
                         r, c_result_valid, c_busy);
            end
        end
    endtask

    initial begin
        last_data = '0;
        last_hit  = 1'b0;
        test_reset();
        test_basic();
        test_truncation();
        test_full_scale();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_abort();
        test_reset_mid_report();
        test_basic();
        test_corner();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
